// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg -- ID/EX pipeline register with stall, flush and a bubble counter.
//
// Captures the decoded instruction from the ID stage and presents it to the EX
// stage one cycle later. Per-edge priority is flush, then stall, then load.
// A "bubble" is an all-zero payload (ex_valid=0, ex_ex=ADD, controls off).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               hold every ex_ output unchanged
//   flush               load a bubble (wins over stall)
//   cnt_clr             synchronous clear of bubble_cnt (wins over a bubble)
//   id_*                decoded fields from the ID stage
//   ex_*                registered copies of the id_ fields for the EX stage
//   bubble_cnt          saturating count of bubbles loaded into EX
// -----------------------------------------------------------------------------
module id_ex_reg #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            cnt_clr,
    input  logic            id_valid,
    input  logic [2:0]      id_ex,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    output logic            ex_valid,
    output logic [2:0]      ex_ex,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_alu_src,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic [CNTW-1:0] bubble_cnt
);

    // Whole stage payload as one packed struct so a bubble is simply '0.
    typedef struct packed {
        logic            valid;
        logic [2:0]      ex;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            alu_src;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
    } ex_stage_t;

    ex_stage_t id_stage;
    ex_stage_t ex_d;
    ex_stage_t ex_q;
    logic      mem_illegal;
    logic      bubble_event;

    assign mem_illegal  = id_mem_read & id_mem_write;
    // A held (stalled) cycle never counts, even if ID is empty.
    assign bubble_event = flush | (~stall & ~id_valid);

    always_comb begin
        // NOTE: every signal written here gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        id_stage            = '0;
        id_stage.valid      = 1'b1;
        id_stage.ex         = id_ex;
        id_stage.rs1_data   = id_rs1_data;
        id_stage.rs2_data   = id_rs2_data;
        id_stage.imm        = id_imm;
        id_stage.pc         = id_pc;
        id_stage.rs1        = id_rs1;
        id_stage.rs2        = id_rs2;
        id_stage.rd         = id_rd;
        id_stage.alu_src    = id_alu_src;
        // x0 is hard-wired zero: never let a write to it reach writeback.
        id_stage.reg_write  = id_reg_write & (id_rd != 5'd0);
        // Read+write together is illegal: drop both memory strobes.
        id_stage.mem_read   = id_mem_read  & ~mem_illegal;
        id_stage.mem_write  = id_mem_write & ~mem_illegal;
        id_stage.mem_to_reg = id_mem_to_reg;

        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d = id_valid ? id_stage : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            ex_q <= ex_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (bubble_event && (bubble_cnt != {CNTW{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_ex         = ex_q.ex;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg -- self-checking bench for id_ex_reg (XLEN=32, CNTW=4).
//
// A table of directed vectors is applied one edge each; hand-written sequences
// then cover counter saturation/clear and asynchronous reset. The secondary
// fields (rs2_data, imm, pc, rs1, rs2, alu_src, mem_to_reg) are driven as
// fixed functions of a per-vector base word so they are checked too.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

    localparam int XLEN = 32;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall, flush, cnt_clr, id_valid;
    logic [2:0]      id_ex;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic            ex_valid;
    logic [2:0]      ex_ex;
    logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic            ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [CNTW-1:0] bubble_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .id_valid(id_valid), .id_ex(id_ex),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .ex_valid(ex_valid), .ex_ex(ex_ex),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        // inputs
        logic            stall, flush, cnt_clr, id_valid;
        logic [2:0]      ex;
        logic [XLEN-1:0] base;
        logic [4:0]      rd;
        logic            rw, mr, mw;
        // expected outputs
        logic            e_valid;
        logic [2:0]      e_ex;
        logic [XLEN-1:0] e_base;
        logic [4:0]      e_rd;
        logic            e_rw, e_mr, e_mw;
        logic [CNTW-1:0] e_cnt;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Secondary fields as a function of the base word; zero for a bubble.
    function automatic logic [107:0] aux_of(input logic valid, input logic [XLEN-1:0] b);
        if (!valid) return '0;
        return {b + 32'd1, b + 32'd2, b + 32'd3, b[4:0], b[9:5], b[0], b[1]};
    endfunction

    task automatic drive(input logic st, input logic fl, input logic clr, input logic v,
                         input logic [2:0] ex, input logic [XLEN-1:0] b, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw);
        stall = st; flush = fl; cnt_clr = clr; id_valid = v; id_ex = ex;
        id_rs1_data = b; id_rs2_data = b + 32'd1; id_imm = b + 32'd2; id_pc = b + 32'd3;
        id_rs1 = b[4:0]; id_rs2 = b[9:5]; id_alu_src = b[0]; id_mem_to_reg = b[1];
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic check_state(input string tag, input logic e_valid, input logic [2:0] e_ex,
                               input logic [XLEN-1:0] e_base, input logic [4:0] e_rd,
                               input logic e_rw, input logic e_mr, input logic e_mw,
                               input logic [CNTW-1:0] e_cnt);
        check({tag, "_valid"}, 128'(ex_valid), 128'(e_valid));
        check({tag, "_ex"},    128'(ex_ex),    128'(e_ex));
        check({tag, "_rs1d"},  128'(ex_rs1_data), 128'(e_base));
        check({tag, "_aux"},
              128'({ex_rs2_data, ex_imm, ex_pc, ex_rs1, ex_rs2, ex_alu_src, ex_mem_to_reg}),
              128'(aux_of(e_valid, e_base)));
        check({tag, "_rd"},    128'(ex_rd), 128'(e_rd));
        check({tag, "_ctl"},   128'({ex_reg_write, ex_mem_read, ex_mem_write}),
              128'({e_rw, e_mr, e_mw}));
        check({tag, "_cnt"},   128'(bubble_cnt), 128'(e_cnt));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, fl, clr, v, input logic [2:0] ex,
                                input logic [XLEN-1:0] b, input logic [4:0] rd,
                                input logic rw, mr, mw,
                                input logic ev, input logic [2:0] eex,
                                input logic [XLEN-1:0] eb, input logic [4:0] erd,
                                input logic erw, emr, emw, input logic [CNTW-1:0] ec);
        vec_t r;
        r.stall = st; r.flush = fl; r.cnt_clr = clr; r.id_valid = v; r.ex = ex; r.base = b;
        r.rd = rd; r.rw = rw; r.mr = mr; r.mw = mw;
        r.e_valid = ev; r.e_ex = eex; r.e_base = eb; r.e_rd = erd;
        r.e_rw = erw; r.e_mr = emr; r.e_mw = emw; r.e_cnt = ec;
        return r;
    endfunction

    initial begin
        //            st fl cl v  ex  base          rd  rw mr mw | v ex base          rd rw mr mw cnt
        vecs[0]  = mk(0, 0, 0, 1, 7, 32'h12345678, 5,  1, 0, 0,  1, 7, 32'h12345678, 5, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 1, 32'h00001111, 3,  1, 0, 0,  1, 1, 32'h00001111, 3, 1, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 1, 4, 32'hAAAA0000, 7,  0, 1, 0,  1, 1, 32'h00001111, 3, 1, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 1, 5, 32'hBBBB0005, 9,  1, 0, 1,  1, 1, 32'h00001111, 3, 1, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 0, 6, 32'hCCCC0006, 4,  1, 0, 0,  1, 1, 32'h00001111, 3, 1, 0, 0, 0);
        vecs[5]  = mk(1, 1, 0, 1, 2, 32'hDDDD0007, 6,  1, 0, 0,  0, 0, 32'h0,        0, 0, 0, 0, 1);
        vecs[6]  = mk(0, 0, 0, 1, 2, 32'h0F0F0F0F, 0,  1, 0, 0,  1, 2, 32'h0F0F0F0F, 0, 0, 0, 0, 1);
        vecs[7]  = mk(0, 0, 0, 1, 3, 32'hCAFEBABE, 10, 1, 1, 1,  1, 3, 32'hCAFEBABE, 10, 1, 0, 0, 1);
        vecs[8]  = mk(0, 0, 0, 1, 4, 32'h00000100, 11, 1, 1, 0,  1, 4, 32'h00000100, 11, 1, 1, 0, 1);
        vecs[9]  = mk(0, 0, 0, 1, 6, 32'h00000203, 12, 0, 0, 1,  1, 6, 32'h00000203, 12, 0, 0, 1, 1);
        vecs[10] = mk(0, 1, 0, 1, 5, 32'h77777777, 13, 1, 0, 0,  0, 0, 32'h0,        0, 0, 0, 0, 2);
        vecs[11] = mk(0, 0, 0, 0, 5, 32'h88888888, 14, 1, 0, 0,  0, 0, 32'h0,        0, 0, 0, 0, 3);
        vecs[12] = mk(0, 0, 1, 1, 5, 32'h00000055, 1,  1, 0, 0,  1, 5, 32'h00000055, 1, 1, 0, 0, 0);
        vecs[13] = mk(0, 1, 1, 1, 3, 32'h99999999, 2,  1, 0, 0,  0, 0, 32'h0,        0, 0, 0, 0, 0);
        vecs[14] = mk(0, 1, 0, 0, 0, 32'h0,        0,  0, 0, 0,  0, 0, 32'h0,        0, 0, 0, 0, 1);

        // Reset state while rst_n is low, before any clock edge.
        rst_n = 1'b0;
        drive(0, 0, 0, 1, 3'd7, 32'hFFFFFFFF, 5'd31, 1, 1, 0);
        #2;
        check_state("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        #6 rst_n = 1'b1;                      // release between edges
        #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].cnt_clr, vecs[i].id_valid, vecs[i].ex,
                  vecs[i].base, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].mw);
            step();
            check_state($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_ex, vecs[i].e_base,
                        vecs[i].e_rd, vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_cnt);
        end

        // Saturation: counter is at 1; 20 empty-ID edges must stop at 15.
        drive(0, 0, 0, 0, 3'd0, 32'h0, 5'd0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step();
        check("sat_cnt", 128'(bubble_cnt), 128'(4'd15));
        drive(0, 1, 1, 0, 3'd0, 32'h0, 5'd0, 0, 0, 0);
        step();
        check("clr_over_flush", 128'(bubble_cnt), 128'(4'd0));
        drive(0, 1, 0, 0, 3'd0, 32'h0, 5'd0, 0, 0, 0);
        step();
        check("flush_after_clr", 128'(bubble_cnt), 128'(4'd1));

        // Build ex_valid=1 with bubble_cnt=9: 8 more flushes, then a valid load.
        for (int i = 0; i < 8; i++) step();
        drive(0, 0, 0, 1, 3'd6, 32'h13572468, 5'd8, 1, 0, 0);
        step();
        check_state("pre_rst", 1, 6, 32'h13572468, 8, 1, 0, 0, 9);

        // Asynchronous reset mid-cycle with stall and flush both active.
        drive(1, 1, 0, 1, 3'd2, 32'h0BADF00D, 5'd9, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_state("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_state("rst_held", 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        drive(0, 0, 0, 1, 3'd4, 32'h2468ACE0, 5'd17, 1, 0, 0);
        #1;
        check("post_rel_cnt", 128'(bubble_cnt), 128'(4'd0));
        step();
        check_state("post_rel_load", 1, 4, 32'h2468ACE0, 17, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
